// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared RAM handshake and arbiter state types
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic [1:0] {IDLE = 2'd0, IBUSY = 2'd1, DBUSY = 2'd2} arb_state_t;
  localparam logic [31:0] BAD_DATA = 32'hBAD1BAD1;
endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: cpu-side and ram-side signals of the memory arbiter
interface memory_arbiter_if import cpu_types_pkg::*; ();
  logic        iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN, merr;
  logic [31:0] iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
  ramstate_t   ramstate;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
  );
endinterface

// File: rtl/arb_timer.sv
// arb_timer: busy-cycle counter, expires on the TIMEOUT-th counted cycle
module arb_timer #(parameter int TIMEOUT = 64) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire = en && cnt_q == LAST;
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: data-priority RAM arbiter with fetch starvation and timeout guards
module memory_arbiter import cpu_types_pkg::*; #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input logic CLK,
  input logic nRST,
  memory_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  arb_state_t  state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic        wr_q, wr_d, merr_q, merr_d;
  logic        busy, dreq, abort, expire, done, err, idone, ddone;
  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(CLK), .rst_n(nRST), .clr(!busy), .en(busy), .expire(expire)
  );
  always_comb begin
    busy  = state_q != IDLE;
    dreq  = bus.dREN | bus.dWEN;
    abort = (state_q == IBUSY && !bus.iREN) || (state_q == DBUSY && !dreq);
    done  = busy && !abort && (bus.ramstate == ACCESS || bus.ramstate == ERROR || expire);
    err   = done && bus.ramstate != ACCESS;
    idone = done && state_q == IBUSY;
    ddone = done && state_q == DBUSY;
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    if (state_q == IDLE) begin
      // a saturated starve count lets a pending fetch jump ahead of data
      if (bus.iREN && (starve_q == SMAX || !dreq)) begin
        state_d = IBUSY;
        addr_d  = bus.iaddr;
        data_d  = '0;
        wr_d    = 1'b0;
      end else if (dreq) begin
        state_d = DBUSY;
        addr_d  = bus.daddr;
        data_d  = bus.dstore;
        wr_d    = bus.dWEN;
      end
    end else if (abort || done) state_d = IDLE;
    starve_d = (!bus.iREN || idone) ? '0 : (ddone && starve_q != SMAX) ? starve_q + 1'b1 : starve_q;
    merr_d   = merr_q | err;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      merr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      merr_q   <= merr_d;
    end
  assign bus.ramREN   = !abort && (state_q == IBUSY || (state_q == DBUSY && !wr_q));
  assign bus.ramWEN   = !abort && state_q == DBUSY && wr_q;
  assign bus.ramaddr  = busy ? addr_q : '0;
  assign bus.ramstore = busy ? data_q : '0;
  assign bus.iwait    = !idone;
  assign bus.dwait    = !ddone;
  assign bus.iload    = idone ? (err ? BAD_DATA : bus.ramload) : '0;
  assign bus.dload    = ddone ? (err ? BAD_DATA : wr_q ? '0 : bus.ramload) : '0;
  assign bus.merr     = merr_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: table-driven cycle vectors through a scoreboard queue, plus a mid-access reset sequence
module tb_memory_arbiter;
  import cpu_types_pkg::*;
  typedef struct {
    logic ir, dr, dw; ramstate_t rs; logic [31:0] rl;
    logic ren, wen, iw, dwt, me; logic [31:0] ad, st, il, dl;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_vec = 0, n_err = 0;
  vec_t vq[$], sb[$];
  memory_arbiter_if bus ();
  memory_arbiter #(.STARVE_MAX(4), .TIMEOUT(64)) dut (.CLK(clk), .nRST(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t v(input logic ir, dr, dw, input ramstate_t rs, input logic [31:0] rl,
                             input logic ren, wen, iw, dwt, me, input logic [31:0] ad, st, il, dl);
    v = '{ir, dr, dw, rs, rl, ren, wen, iw, dwt, me, ad, st, il, dl};
  endfunction
  function automatic vec_t idle(input logic ir, dr, dw, me);
    idle = v(ir, dr, dw, FREE, 32'h0, 0, 0, 1, 1, me, 32'h0, 32'h0, 32'h0, 32'h0);
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic run_vecs();
    vec_t e;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      bus.iREN = vq[i].ir; bus.dREN = vq[i].dr; bus.dWEN = vq[i].dw;
      bus.ramstate = vq[i].rs; bus.ramload = vq[i].rl;
      sb.push_back(vq[i]);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d ramREN", i), {31'h0, bus.ramREN}, {31'h0, e.ren});
      chk($sformatf("v%0d ramWEN", i), {31'h0, bus.ramWEN}, {31'h0, e.wen});
      chk($sformatf("v%0d iwait", i), {31'h0, bus.iwait}, {31'h0, e.iw});
      chk($sformatf("v%0d dwait", i), {31'h0, bus.dwait}, {31'h0, e.dwt});
      chk($sformatf("v%0d merr", i), {31'h0, bus.merr}, {31'h0, e.me});
      chk($sformatf("v%0d ramaddr", i), bus.ramaddr, e.ad);
      chk($sformatf("v%0d ramstore", i), bus.ramstore, e.st);
      chk($sformatf("v%0d iload", i), bus.iload, e.il);
      chk($sformatf("v%0d dload", i), bus.dload, e.dl);
    end
    vq.delete();
  endtask
  initial begin
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; bus.ramstate = FREE; bus.ramload = 0;
    bus.iaddr = 32'h40; bus.daddr = 32'h100; bus.dstore = 32'hDEAD;
    #1;
    chk("rst iwait", {31'h0, bus.iwait}, 32'h1);
    chk("rst dwait", {31'h0, bus.dwait}, 32'h1);
    chk("rst ramREN", {31'h0, bus.ramREN}, 32'h0);
    chk("rst ramaddr", bus.ramaddr, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    vq.push_back(idle(0, 0, 0, 0));
    vq.push_back(idle(1, 0, 0, 0));
    repeat (2) vq.push_back(v(1, 0, 0, BUSY, 0, 1, 0, 1, 1, 0, 32'h40, 0, 0, 0));
    vq.push_back(v(1, 0, 0, ACCESS, 32'h8C010004, 1, 0, 0, 1, 0, 32'h40, 0, 32'h8C010004, 0));
    vq.push_back(idle(0, 0, 0, 0));
    vq.push_back(idle(1, 0, 1, 0));
    vq.push_back(v(1, 0, 1, BUSY, 0, 0, 1, 1, 1, 0, 32'h100, 32'hDEAD, 0, 0));
    vq.push_back(v(1, 0, 1, ACCESS, 32'h12345678, 0, 1, 1, 0, 0, 32'h100, 32'hDEAD, 0, 0));
    vq.push_back(idle(1, 0, 0, 0));
    vq.push_back(v(1, 0, 0, ACCESS, 32'hAAAA5555, 1, 0, 0, 1, 0, 32'h40, 0, 32'hAAAA5555, 0));
    vq.push_back(idle(0, 0, 0, 0));
    for (int k = 1; k <= 4; k++) begin
      vq.push_back(idle(1, 1, 0, 0));
      vq.push_back(v(1, 1, 0, ACCESS, k, 1, 0, 1, 0, 0, 32'h100, 32'hDEAD, 0, k));
    end
    vq.push_back(idle(1, 1, 0, 0));
    vq.push_back(v(1, 1, 0, ACCESS, 32'hF00D, 1, 0, 0, 1, 0, 32'h40, 0, 32'hF00D, 0));
    vq.push_back(idle(1, 1, 0, 0));
    vq.push_back(v(1, 1, 0, ACCESS, 32'h5, 1, 0, 1, 0, 0, 32'h100, 32'hDEAD, 0, 32'h5));
    vq.push_back(idle(0, 0, 0, 0));
    vq.push_back(idle(1, 0, 0, 0));
    vq.push_back(v(1, 0, 0, BUSY, 0, 1, 0, 1, 1, 0, 32'h40, 0, 0, 0));
    vq.push_back(v(0, 0, 0, BUSY, 0, 0, 0, 1, 1, 0, 32'h40, 0, 0, 0));
    vq.push_back(idle(0, 0, 0, 0));
    vq.push_back(idle(1, 0, 0, 0));
    vq.push_back(v(1, 0, 0, BUSY, 0, 1, 0, 1, 1, 0, 32'h40, 0, 0, 0));
    vq.push_back(v(0, 0, 0, ACCESS, 32'h77, 0, 0, 1, 1, 0, 32'h40, 0, 0, 0));
    vq.push_back(idle(0, 0, 0, 0));
    vq.push_back(idle(0, 1, 0, 0));
    vq.push_back(v(0, 1, 0, ERROR, 32'h1234, 1, 0, 1, 0, 0, 32'h100, 32'hDEAD, 0, 32'hBAD1BAD1));
    vq.push_back(idle(0, 0, 0, 1));
    vq.push_back(idle(0, 0, 0, 1));
    run_vecs();
    @(negedge clk);
    bus.dWEN = 1; bus.ramstate = FREE;
    @(negedge clk);
    bus.ramstate = BUSY;
    #1;
    chk("pre-rst ramWEN", {31'h0, bus.ramWEN}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-rst ramWEN", {31'h0, bus.ramWEN}, 32'h0);
    chk("mid-rst iwait", {31'h0, bus.iwait}, 32'h1);
    chk("mid-rst dwait", {31'h0, bus.dwait}, 32'h1);
    chk("mid-rst merr", {31'h0, bus.merr}, 32'h0);
    chk("mid-rst ramaddr", bus.ramaddr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; bus.dWEN = 0;
    vq.push_back(idle(0, 1, 0, 0));
    repeat (63) vq.push_back(v(0, 1, 0, BUSY, 0, 1, 0, 1, 1, 0, 32'h100, 32'hDEAD, 0, 0));
    vq.push_back(v(0, 1, 0, BUSY, 0, 1, 0, 1, 0, 0, 32'h100, 32'hDEAD, 0, 32'hBAD1BAD1));
    vq.push_back(idle(0, 0, 0, 1));
    run_vecs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
